// File: rtl/tone_seq_if.sv
// tone_seq_if: control/table-write bus into tone_sequencer and its generator-side outputs.
interface tone_seq_if #(
    parameter int AW    = 3,
    parameter int DUR_W = 16
);
    logic             wr_en;
    logic [AW-1:0]    wr_addr;
    logic [15:0]      wr_step;
    logic [1:0]       wr_duty;
    logic [DUR_W-1:0] wr_dur;
    logic             start;
    logic             stop;
    logic             loop_en;
    logic [15:0]      step;
    logic [1:0]       duty;
    logic             gen_reset;
    logic             busy;
    logic [AW-1:0]    cur_idx;
    logic             done;

    modport master (
        output wr_en, wr_addr, wr_step, wr_duty, wr_dur, start, stop, loop_en,
        input  step, duty, gen_reset, busy, cur_idx, done
    );

    modport slave (
        input  wr_en, wr_addr, wr_step, wr_duty, wr_dur, start, stop, loop_en,
        output step, duty, gen_reset, busy, cur_idx, done
    );
endinterface

// File: rtl/tone_sequencer.sv
// tone_sequencer: steps through a (step, duty, duration) note table driving a square-wave generator.
// Define TONE_SEQ_GLIDE_EN to glide step between the notes of a running sequence.
module tone_sequencer #(
    parameter int DEPTH    = 8,
    parameter int DUR_W    = 16,
    parameter int PRESCALE = 1000
) (
    input logic       clk,
    input logic       reset,
    tone_seq_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int PW = PRESCALE > 1 ? $clog2(PRESCALE) : 1;

    typedef enum logic [1:0] {IDLE, LOAD, PLAY} state_t;
    typedef struct packed {
        logic [15:0]      step;
        logic [1:0]       duty;
        logic [DUR_W-1:0] dur;
    } entry_t;

    entry_t           table_q [DEPTH];
    entry_t           ent;
    state_t           state_q, state_d;
    logic [15:0]      step_q, step_d;
    logic [1:0]       duty_q, duty_d;
    logic             gen_reset_q, gen_reset_d;
    logic             busy_q, busy_d;
    logic [AW-1:0]    idx_q, idx_d;
    logic             done_q, done_d;
    logic [DUR_W-1:0] rem_q, rem_d;
    logic [PW-1:0]    pre_q, pre_d;
    logic             tick;
`ifdef TONE_SEQ_GLIDE_EN
    logic [15:0]      target_q, target_d, gap, inc;
    logic             first_q, first_d;
`endif

    assign ent  = table_q[idx_q];
    assign tick = pre_q == PW'(PRESCALE - 1);

    // Note table is deliberately not reset; outputs only change when an entry is loaded.
    always_ff @(posedge clk)
        if (bus.wr_en) table_q[bus.wr_addr] <= {bus.wr_step, bus.wr_duty, bus.wr_dur};

`ifdef TONE_SEQ_GLIDE_EN
    assign gap = step_q < target_q ? target_q - step_q : step_q - target_q;
    assign inc = gap[15:4] == '0 ? 16'd1 : {4'd0, gap[15:4]};
`endif

    always_comb begin
        state_d = state_q;
        step_d  = step_q;
        duty_d  = duty_q;
        idx_d   = idx_q;
        done_d  = 1'b0;
        rem_d   = rem_q;
        pre_d   = pre_q;
`ifdef TONE_SEQ_GLIDE_EN
        target_d = target_q;
        first_d  = first_q;
`endif
        if (bus.stop)
            state_d = IDLE;
        else
            case (state_q)
                IDLE: if (bus.start) begin
                    state_d = LOAD;
                    idx_d   = '0;
`ifdef TONE_SEQ_GLIDE_EN
                    first_d = 1'b1;
`endif
                end
                LOAD: if (ent.dur != '0) begin
                    state_d = PLAY;
                    duty_d  = ent.duty;
                    rem_d   = ent.dur;
                    pre_d   = '0;
`ifdef TONE_SEQ_GLIDE_EN
                    target_d = ent.step;
                    step_d   = first_q ? ent.step : step_q;
                    first_d  = 1'b0;
`else
                    step_d   = ent.step;
`endif
                end else if (idx_q != '0 && bus.loop_en)
                    idx_d = '0;
                else begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
                PLAY: if (tick) begin
                    pre_d = '0;
                    rem_d = rem_q - DUR_W'(1);
`ifdef TONE_SEQ_GLIDE_EN
                    step_d = step_q < target_q ? step_q + inc : step_q > target_q ? step_q - inc : step_q;
`endif
                    // Running off the last entry behaves like hitting an end marker, without the LOAD cycle.
                    if (rem_q == DUR_W'(1)) begin
                        if (idx_q != AW'(DEPTH - 1)) begin
                            idx_d   = idx_q + AW'(1);
                            state_d = LOAD;
                        end else if (bus.loop_en) begin
                            idx_d   = '0;
                            state_d = LOAD;
                        end else begin
                            state_d = IDLE;
                            done_d  = 1'b1;
                        end
                    end
                end else
                    pre_d = pre_q + PW'(1);
                default: state_d = IDLE;
            endcase
        busy_d = state_d != IDLE;
`ifdef TONE_SEQ_GLIDE_EN
        gen_reset_d = state_d == IDLE || (state_d == LOAD && first_d);
`else
        gen_reset_d = state_d != PLAY;
`endif
    end

    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            state_q     <= IDLE;
            step_q      <= '0;
            duty_q      <= 2'b01;
            gen_reset_q <= 1'b1;
            busy_q      <= 1'b0;
            idx_q       <= '0;
            done_q      <= 1'b0;
            rem_q       <= '0;
            pre_q       <= '0;
`ifdef TONE_SEQ_GLIDE_EN
            target_q    <= '0;
            first_q     <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            step_q      <= step_d;
            duty_q      <= duty_d;
            gen_reset_q <= gen_reset_d;
            busy_q      <= busy_d;
            idx_q       <= idx_d;
            done_q      <= done_d;
            rem_q       <= rem_d;
            pre_q       <= pre_d;
`ifdef TONE_SEQ_GLIDE_EN
            target_q    <= target_d;
            first_q     <= first_d;
`endif
        end

    assign bus.step      = step_q;
    assign bus.duty      = duty_q;
    assign bus.gen_reset = gen_reset_q;
    assign bus.busy      = busy_q;
    assign bus.cur_idx   = idx_q;
    assign bus.done      = done_q;
endmodule

// File: tb/tb_tone_sequencer.sv
// tb_tone_sequencer: table-driven directed checks of tone_sequencer playback, looping, stop and reset.
module tb_tone_sequencer;
    typedef struct {
        int          n;
        logic        start;
        logic        stop;
        logic        loop_en;
        logic [15:0] step;
        logic [1:0]  duty;
        logic        gr;
        logic        busy;
        logic [2:0]  idx;
        logic        done;
    } vec_t;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    int   total = 0;
    int   bad   = 0;
    int   ptr   = 0;
    int   mark [7];
    vec_t vq [$];

    tone_seq_if #(.AW(3), .DUR_W(16)) bus ();

    tone_sequencer #(.DEPTH(8), .DUR_W(16), .PRESCALE(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic add(input int n, input logic st, input logic sp, input logic lp,
                       input logic [15:0] s, input logic [1:0] d, input logic g,
                       input logic b, input logic [2:0] i, input logic dn);
        vq.push_back('{n, st, sp, lp, s, d, g, b, i, dn});
    endtask

    task automatic check(input string name, input logic [15:0] s, input logic [1:0] d,
                         input logic g, input logic b, input logic [2:0] i, input logic dn);
        logic [23:0] got, exp;
        got = {bus.step, bus.duty, bus.gen_reset, bus.busy, b ? bus.cur_idx : 3'd0, bus.done};
        exp = {s, d, g, b, b ? i : 3'd0, dn};
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got step=%h duty=%b gen_reset=%b busy=%b idx=%0d done=%b, want step=%h duty=%b gen_reset=%b busy=%b idx=%0d done=%b",
                     name, bus.step, bus.duty, bus.gen_reset, bus.busy, bus.cur_idx, bus.done,
                     s, d, g, b, i, dn);
        end
    endtask

    task automatic arm(input logic [2:0] a, input logic [15:0] s, input logic [1:0] d, input logic [15:0] t);
        bus.wr_addr = a;
        bus.wr_step = s;
        bus.wr_duty = d;
        bus.wr_dur  = t;
        bus.wr_en   = 1'b1;
    endtask

    task automatic wr(input logic [2:0] a, input logic [15:0] s, input logic [1:0] d, input logic [15:0] t);
        arm(a, s, d, t);
        @(posedge clk);
        #1;
        bus.wr_en = 1'b0;
    endtask

    task automatic run_to(input int upto);
        while (ptr < upto) begin
            for (int k = 0; k < vq[ptr].n; k++) begin
                bus.start   = vq[ptr].start;
                bus.stop    = vq[ptr].stop;
                bus.loop_en = vq[ptr].loop_en;
                @(posedge clk);
                #1;
                bus.wr_en = 1'b0;
                bus.start = 1'b0;
                bus.stop  = 1'b0;
                check($sformatf("row%0d.%0d", ptr, k), vq[ptr].step, vq[ptr].duty,
                      vq[ptr].gr, vq[ptr].busy, vq[ptr].idx, vq[ptr].done);
            end
            ptr++;
        end
    endtask

    initial begin
        bus.wr_en   = 1'b0;
        bus.wr_addr = '0;
        bus.wr_step = '0;
        bus.wr_duty = '0;
        bus.wr_dur  = '0;
        bus.start   = 1'b0;
        bus.stop    = 1'b0;
        bus.loop_en = 1'b0;

        // one-shot: e0 3 ticks, e1 2 ticks, e2 end marker; a start mid-play is ignored
        add(1, 1, 0, 0, 16'h0000, 2'b01, 1, 1, 0, 0);
        add(5, 0, 0, 0, 16'h0100, 2'b01, 0, 1, 0, 0);
        add(1, 1, 0, 0, 16'h0100, 2'b01, 0, 1, 0, 0);
        add(6, 0, 0, 0, 16'h0100, 2'b01, 0, 1, 0, 0);
        add(1, 0, 0, 0, 16'h0100, 2'b01, 1, 1, 1, 0);
        add(8, 0, 0, 0, 16'h0400, 2'b10, 0, 1, 1, 0);
        add(1, 0, 0, 0, 16'h0400, 2'b10, 1, 1, 2, 0);
        add(1, 0, 0, 0, 16'h0400, 2'b10, 1, 0, 2, 1);
        add(2, 0, 0, 0, 16'h0400, 2'b10, 1, 0, 2, 0);
        mark[0] = vq.size();
        // looping, with e0 rewritten while it plays
        add(1, 1, 0, 1, 16'h0400, 2'b10, 1, 1, 0, 0);
        add(1, 0, 0, 1, 16'h0100, 2'b01, 0, 1, 0, 0);
        mark[1] = vq.size();
        add(11, 0, 0, 1, 16'h0100, 2'b01, 0, 1, 0, 0);
        add(1, 0, 0, 1, 16'h0100, 2'b01, 1, 1, 1, 0);
        add(8, 0, 0, 1, 16'h0400, 2'b10, 0, 1, 1, 0);
        add(1, 0, 0, 1, 16'h0400, 2'b10, 1, 1, 2, 0);
        add(1, 0, 0, 1, 16'h0400, 2'b10, 1, 1, 0, 0);
        add(2, 0, 0, 1, 16'h0999, 2'b01, 0, 1, 0, 0);
        add(1, 0, 1, 1, 16'h0999, 2'b01, 1, 0, 0, 0);
        add(2, 0, 0, 0, 16'h0999, 2'b01, 1, 0, 0, 0);
        mark[2] = vq.size();
        // start, then async reset lands mid-PLAY
        add(1, 1, 0, 0, 16'h0999, 2'b01, 1, 1, 0, 0);
        add(3, 0, 0, 0, 16'h0100, 2'b01, 0, 1, 0, 0);
        mark[3] = vq.size();
        // empty table right after reset
        add(1, 1, 0, 0, 16'h0000, 2'b01, 1, 1, 0, 0);
        add(1, 0, 0, 0, 16'h0000, 2'b01, 1, 0, 0, 1);
        add(1, 0, 0, 0, 16'h0000, 2'b01, 1, 0, 0, 0);
        mark[4] = vq.size();
        // replay from e0, then stop during a LOAD leaves step untouched
        add(1, 1, 0, 0, 16'h0000, 2'b01, 1, 1, 0, 0);
        add(12, 0, 0, 0, 16'h0100, 2'b01, 0, 1, 0, 0);
        add(1, 0, 0, 0, 16'h0100, 2'b01, 1, 1, 1, 0);
        add(1, 0, 1, 0, 16'h0100, 2'b01, 1, 0, 1, 0);
        mark[5] = vq.size();
        // full table of 1-tick notes, natural end after entry 7
        add(1, 1, 0, 0, 16'h0100, 2'b01, 1, 1, 0, 0);
        for (int i = 0; i < 8; i++) begin
            add(4, 0, 0, 0, 16'(16 * (i + 1)), 2'(i), 0, 1, 3'(i), 0);
            if (i < 7) add(1, 0, 0, 0, 16'(16 * (i + 1)), 2'(i), 1, 1, 3'(i + 1), 0);
        end
        add(1, 0, 0, 0, 16'h0080, 2'b11, 1, 0, 7, 1);
        add(1, 0, 0, 0, 16'h0080, 2'b11, 1, 0, 7, 0);
        mark[6] = vq.size();
        // start and stop together in IDLE
        add(1, 1, 1, 0, 16'h0080, 2'b11, 1, 0, 0, 0);
        add(2, 0, 0, 0, 16'h0080, 2'b11, 1, 0, 0, 0);

        #1 reset = 1'b1;
        #1 check("reset", 16'h0000, 2'b01, 1, 0, 0, 0);
        repeat (2) @(posedge clk);
        #2 reset = 1'b0;
        wr(0, 16'h0100, 2'b01, 16'd3);
        wr(1, 16'h0400, 2'b10, 16'd2);
        wr(2, 16'h0000, 2'b00, 16'd0);
        run_to(mark[0]);
        run_to(mark[1]);
        arm(0, 16'h0999, 2'b01, 16'd3);
        run_to(mark[2]);
        wr(0, 16'h0100, 2'b01, 16'd3);
        run_to(mark[3]);
        #2 reset = 1'b1;
        #1 check("async_reset", 16'h0000, 2'b01, 1, 0, 0, 0);
        @(posedge clk);
        #1 check("reset_held", 16'h0000, 2'b01, 1, 0, 0, 0);
        #2 reset = 1'b0;
        wr(0, 16'h0100, 2'b01, 16'd0);
        run_to(mark[4]);
        wr(0, 16'h0100, 2'b01, 16'd3);
        run_to(mark[5]);
        for (int i = 0; i < 8; i++) wr(3'(i), 16'(16 * (i + 1)), 2'(i), 16'd1);
        run_to(mark[6]);
        run_to(vq.size());
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
